// File: rtl/mem_burst_reader.sv
// mem_burst_reader
//
// Burst read engine for the single-port, synchronous-read vertex/bounding-data RAM.
// On a start request it latches a base address.
// It then reads BURST_LEN consecutive words (base .. base+6, wrapping modulo the RAM depth).
// The words are presented together on out_data0..out_data6 with a valid/ready handshake.
// A group written at address A by the burst write path is recovered by a burst started at A.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - burst request, only looked at while idle
//   base_addr  - first word address, captured when start is accepted
//   busy       - high whenever the engine is not idle
//   ram_cs     - RAM chip select (high only while reading)
//   ram_oe     - RAM output enable (high only while reading)
//   ram_we     - RAM write enable, tied low
//   ram_addr   - RAM read address
//   ram_rdata  - RAM read data, one cycle after the address
//   out_data0..out_data6 - burst words, out_dataN = mem[base+N]
//   out_valid  - burst group valid
//   out_ready  - consumer accepts the group
module mem_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BURST_LEN  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [DATA_WIDTH-1:0] out_data4,
  output logic [DATA_WIDTH-1:0] out_data5,
  output logic [DATA_WIDTH-1:0] out_data6,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // The counter must reach BURST_LEN itself: the last word arrives one cycle after its address.
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] MAX_OFF = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    VALID
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      k;
  logic [CNT_W-1:0]      k_off;
  logic [DATA_WIDTH-1:0] data_q [BURST_LEN];

  // State register; reset drops any burst in flight straight back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only honoured in IDLE, so a request made on the
  // handshake edge is dropped rather than queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)        state_next = READ;
      READ:    if (k == LAST_K)  state_next = VALID;
      VALID:   if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Base latch and word counter. The counter holds at LAST_K after the burst.
  // That keeps ram_addr parked on its final value through VALID and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      k      <= '0;
    end else if (state == IDLE && start) begin
      base_q <= base_addr;
      k      <= '0;
    end else if (state == READ && k != LAST_K) begin
      k <= k + 1'b1;
    end
  end

  // Capture registers: the word addressed at count k-1 is on ram_rdata while the count is k.
  // Registers are only overwritten during a burst, so they keep their values after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        data_q[i] <= '0;
      end
    end else if (state == READ) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        if (k == CNT_W'(i + 1)) begin
          data_q[i] <= ram_rdata;
        end
      end
    end
  end

  // The final READ cycle re-issues the last address.
  // Chip select therefore stays asserted while word 6 is sampled.
  assign k_off    = (k > MAX_OFF) ? MAX_OFF : k;
  assign ram_addr = base_q + ADDR_WIDTH'(k_off);

  assign ram_cs    = (state == READ);
  assign ram_oe    = (state == READ);
  assign ram_we    = 1'b0;
  assign busy      = (state != IDLE);
  assign out_valid = (state == VALID);

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_data4 = data_q[4];
  assign out_data5 = data_q[5];
  assign out_data6 = data_q[6];

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader
//
// Directed bench for mem_burst_reader.
// A behavioural registered-read RAM is preloaded with known words.
// Directed bursts are then issued, and the address sequence, timing and returned group are checked.
// Ports of the DUT are all driven/observed from here.
module tb_mem_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic        busy;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_rdata;
  logic [31:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5, out_data6;
  logic        out_valid;
  logic        out_ready;

  logic [31:0] mem [64];
  logic [31:0] obs [7];

  int checks = 0;
  int errors = 0;

  mem_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .ram_cs    (ram_cs),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_data4 (out_data4),
    .out_data5 (out_data5),
    .out_data6 (out_data6),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-read RAM; returns a poison word when not selected so a missing
  // chip select shows up in the captured data.
  always @(posedge clk) begin
    if (ram_cs && ram_oe && !ram_we) ram_rdata <= mem[ram_addr];
    else                             ram_rdata <= 32'hDEAD_BEEF;
  end

  assign obs[0] = out_data0;
  assign obs[1] = out_data1;
  assign obs[2] = out_data2;
  assign obs[3] = out_data3;
  assign obs[4] = out_data4;
  assign obs[5] = out_data5;
  assign obs[6] = out_data6;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expWord(input int base, input int n);
    return mem[(base + n) % 64];
  endfunction

  task automatic checkGroup(input string tag, input int base);
    for (int n = 0; n < 7; n++) begin
      checkOutput($sformatf("%s data%0d", tag, n), obs[n], expWord(base, n));
    end
  endtask

  // One full burst with address/timing checks.
  // stallCycles holds out_ready low in VALID.
  // pokeStart pulses start with a bogus base in READ cycles 3 and 7 and on the handshake edge.
  task automatic applyStimulus(input string tag, input int base, input int stallCycles, input bit pokeStart);
    int addrExp;
    out_ready = 1'b0;
    base_addr = 6'(base);
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, " busy@c0"}, 32'(busy), 32'd1);
    checkOutput({tag, " cs@c0"}, 32'(ram_cs), 32'd1);
    checkOutput({tag, " oe@c0"}, 32'(ram_oe), 32'd1);
    checkOutput({tag, " addr@c0"}, 32'(ram_addr), 32'(base % 64));
    for (int c = 1; c < 8; c++) begin
      if (pokeStart && (c == 3 || c == 7)) begin
        start     = 1'b1;
        base_addr = 6'd40;
      end else begin
        start = 1'b0;
      end
      tick();
      start   = 1'b0;
      addrExp = (base + ((c > 6) ? 6 : c)) % 64;
      checkOutput($sformatf("%s addr@c%0d", tag, c), 32'(ram_addr), 32'(addrExp));
      checkOutput($sformatf("%s cs@c%0d", tag, c), 32'(ram_cs), 32'd1);
      checkOutput($sformatf("%s busy@c%0d", tag, c), 32'(busy), 32'd1);
      checkOutput($sformatf("%s valid@c%0d", tag, c), 32'(out_valid), 32'd0);
    end
    tick();
    checkOutput({tag, " valid@8"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " cs@valid"}, 32'(ram_cs), 32'd0);
    checkOutput({tag, " oe@valid"}, 32'(ram_oe), 32'd0);
    checkOutput({tag, " busy@valid"}, 32'(busy), 32'd1);
    checkGroup(tag, base);
    for (int s = 0; s < stallCycles; s++) begin
      tick();
      checkOutput($sformatf("%s stall%0d valid", tag, s), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s stall%0d cs", tag, s), 32'(ram_cs), 32'd0);
      checkOutput($sformatf("%s stall%0d addr", tag, s), 32'(ram_addr), 32'((base + 6) % 64));
      checkGroup($sformatf("%s stall%0d", tag, s), base);
    end
    out_ready = 1'b1;
    if (pokeStart) begin
      start     = 1'b1;
      base_addr = 6'd40;
    end
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, " valid@hs"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " busy@hs"}, 32'(busy), 32'd0);
    checkOutput({tag, " cs@hs"}, 32'(ram_cs), 32'd0);
    tick();
    checkOutput({tag, " busy@idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " valid@idle"}, 32'(out_valid), 32'd0);
    checkGroup({tag, " held"}, base);
  endtask

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
    end
    for (int i = 60; i < 64; i++) begin
      mem[i] = 32'hC0DE_0000 + 32'(i * 17);
    end
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 6'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cs", 32'(ram_cs), 32'd0);
    checkOutput("reset oe", 32'(ram_oe), 32'd0);
    checkOutput("reset we", 32'(ram_we), 32'd0);
    checkOutput("reset addr", 32'(ram_addr), 32'd0);
    checkOutput("reset valid", 32'(out_valid), 32'd0);
    for (int n = 0; n < 7; n++) begin
      checkOutput($sformatf("reset data%0d", n), obs[n], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] basic burst, base 0");
    applyStimulus("basic", 0, 0, 1'b0);
    checkOutput("basic data0 const", out_data0, 32'h1000_0000);
    checkOutput("basic data6 const", out_data6, 32'h1000_0006);

    $display("[TB] wrap burst, base 60");
    applyStimulus("wrap", 60, 0, 1'b0);
    checkOutput("wrap data4 const", out_data4, 32'h1000_0000);
    checkOutput("wrap data6 const", out_data6, 32'h1000_0002);

    $display("[TB] backpressure, base 7");
    applyStimulus("bp", 7, 5, 1'b0);

    $display("[TB] start while busy, base 14");
    applyStimulus("poke", 14, 0, 1'b1);

    $display("[TB] reset mid-burst, base 21");
    base_addr = 6'd21;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst cs", 32'(ram_cs), 32'd0);
    checkOutput("rst oe", 32'(ram_oe), 32'd0);
    checkOutput("rst valid", 32'(out_valid), 32'd0);
    for (int n = 0; n < 7; n++) begin
      checkOutput($sformatf("rst data%0d", n), obs[n], 32'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus("after rst", 21, 0, 1'b0);

    $display("[TB] back-to-back, base 0 then 7");
    out_ready = 1'b1;
    base_addr = 6'd0;
    start     = 1'b1;
    tick();
    base_addr = 6'd7;
    repeat (8) tick();
    checkOutput("b2b first valid", 32'(out_valid), 32'd1);
    checkGroup("b2b first", 0);
    tick();
    checkOutput("b2b hs busy", 32'(busy), 32'd0);
    checkOutput("b2b hs valid", 32'(out_valid), 32'd0);
    tick();
    start = 1'b0;
    checkOutput("b2b second busy", 32'(busy), 32'd1);
    checkOutput("b2b second addr", 32'(ram_addr), 32'd7);
    repeat (7) tick();
    checkOutput("b2b second early valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("b2b second valid", 32'(out_valid), 32'd1);
    checkGroup("b2b second", 7);
    tick();
    checkOutput("b2b end busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
